dffr_pipeline: RTL and testbench
================================

// Module: dffr_pipeline
// PURPOSE
//   Parametrised, multi-stage pipeline of enable/reset registers with valid/ready flow control.
//   Each stage holds WIDTH data bits plus a valid bit. Bubbles collapse: a stage accepts new data when it is empty or when its contents move on.
//   Sits between a producer and a consumer that can stall. It replaces hand-chained single DFFR instances.
// PARAMETERS
//   WIDTH  8      data width per stage (>=1)
//   DEPTH  3      number of register stages (>=1); nominal latency in cycles
//   RVAL   '0     reset value loaded into every stage data register (WIDTH bits)
// PORTS
//   clk        in   1                 clock; all state updates on posedge
//   reset      in   1                 asynchronous, active-high reset
//   flush      in   1                 synchronous clear of all valid bits
//   in_valid   in   1                 producer presents in_data
//   in_ready   out  1                 stage 0 can accept this cycle
//   in_data    in   WIDTH             input data
//   out_valid  out  1                 last stage holds valid data
//   out_ready  in   1                 consumer accepts out_data
//   out_data   out  WIDTH             data of stage DEPTH-1
//   occupancy  out  $clog2(DEPTH+1)   number of valid stages (only with DFFR_PIPE_OCC_EN)
// BEHAVIOUR
//   Reset (async, posedge reset): all valid[i]=0 and all data[i]=RVAL.
//     Outputs during reset: out_valid=0, out_data=RVAL, in_ready=0, occupancy=0.
//     Reset takes effect immediately and may land mid-transfer; in-flight data is discarded.
//   Advance rule, with i=DEPTH-1 the last stage:
//     adv[DEPTH-1] = valid[DEPTH-1] & out_ready
//     for i<DEPTH-1: adv[i] = valid[i] & (~valid[i+1] | adv[i+1])
//   Stage load: stage i loads when its upstream advances. Upstream is in_valid&in_ready for i=0, and adv[i-1] otherwise.
//     On load: data[i] <= upstream data; valid[i] <= 1.
//     Else if adv[i]: valid[i] <= 0.
//     Else: stage holds.
//   Data registers update only on load. They are not cleared on drain, so an empty stage retains stale data.
//   in_ready = ~flush & (~valid[0] | adv[0]). It is combinational, with no dependency on in_valid.
//   out_valid = valid[DEPTH-1]; out_data = data[DEPTH-1]. Both are registered and have no combinational path from in_*.
//   Latency: with out_ready held at 1 and no stalls, a word accepted at edge N appears on out_* after edge N+DEPTH-1.
//     Throughput is one word per cycle.
//   Full: all valid=1 and out_ready=0 gives in_ready=0.
//     If out_ready=1 while full, in_ready=1 in the same cycle and all stages shift together (no bubble).
//   Empty: out_valid=0; out_ready is ignored.
//   Stall: a stage holds its data and valid while valid[i] & ~adv[i]. Data never changes while out_valid=1 and out_ready=0.
//   Flush (synchronous): at the edge, all valid[i] <= 0 and data holds.
//     Flush overrides any simultaneous load or advance.
//     in_ready=0 while flush=1, so no input handshake completes.
//     An output handshake in the flush cycle (out_valid&out_ready) counts as consumed.
//   Simultaneous in and out handshake with DEPTH=1: the stage reloads and valid stays 1.
// CONFIGURATION
//   DFFR_PIPE_OCC_EN defined:
//     occupancy port is present and registered.
//     It equals popcount(valid) after each edge, is 0 on reset and 0 after flush.
//     It updates by +1 on input handshake only, -1 on output handshake only, and holds when both or neither occur.
//   DFFR_PIPE_OCC_EN undefined: occupancy port and counter are absent. All other behaviour is identical.
// TESTING (WIDTH=8, DEPTH=3, RVAL=8'hA5)
//   1. Reset:
//      Assert reset mid-cycle -> out_valid=0, out_data=8'hA5, in_ready=0 immediately.
//      Release reset -> in_ready=1.
//   2. Streaming:
//      Drive 8'h01,02,03,04 on consecutive cycles with out_ready=1 -> 8'h01 on out after 3 edges, then one word per cycle in order.
//   3. Backpressure:
//      out_ready=0 and push 8'h10,11,12 -> in_ready=0 after the 3rd push; out_data holds 8'h10.
//      Raise out_ready with in_valid=1 (8'h13) -> in_ready=1 that cycle and out shows 8'h10,11,12,13 in order.
//   4. Bubble collapse:
//      Push 8'h20, idle 2 cycles, push 8'h21, with out_ready=0 -> the two words sit in stages 2 and 1 and out_valid=1.
//      Release out_ready -> 8'h20 then 8'h21 on consecutive cycles.
//   5. Flush:
//      Fill 3 words, then flush=1 with in_valid=1 (8'h30) -> in_ready=0; next cycle out_valid=0.
//      8'h30 is never output; occupancy=0 (OCC_EN).
//   6. Occupancy (OCC_EN):
//      Push 2 words with out_ready=0 -> occupancy=2.
//      Simultaneous push and pop -> stays 2.
//      Drain -> 0.

Source files
------------

// File: rtl/dffr_pipeline_if.sv
// rtl/dffr_pipeline_if.sv - producer/consumer handshake bundle for dffr_pipeline (occupancy only with DFFR_PIPE_OCC_EN)
interface dffr_pipeline_if #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 3
);
    logic             flush;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
`ifdef DFFR_PIPE_OCC_EN
    logic [$clog2(DEPTH+1)-1:0] occupancy;

    modport master (
        output flush, in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, occupancy
    );
    modport slave (
        input  flush, in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, occupancy
    );
`else
    modport master (
        output flush, in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data
    );
    modport slave (
        input  flush, in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data
    );
`endif
endinterface

// File: rtl/dffr_pipeline.sv
// rtl/dffr_pipeline.sv - valid/ready register pipeline with bubble collapse; DFFR_PIPE_OCC_EN adds an occupancy counter
module dffr_pipeline #(
    parameter int               WIDTH = 8,
    parameter int               DEPTH = 3,
    parameter logic [WIDTH-1:0] RVAL  = '0
) (
    input  logic             clk,
    input  logic             reset,
    dffr_pipeline_if.slave   bus
);

    logic [DEPTH-1:0] valid_q;
    logic [DEPTH-1:0] valid_d;
    logic [DEPTH-1:0] adv;
    logic [DEPTH-1:0] load;
    logic [WIDTH-1:0] data_q [DEPTH];
    logic [WIDTH-1:0] data_d [DEPTH];
    logic             in_ready;
    logic             in_hs;
    logic             out_hs;

    // Advance chain, evaluated from the output back so each stage sees its downstream decision.
    always_comb begin
        adv = '0;
        adv[DEPTH-1] = valid_q[DEPTH-1] & bus.out_ready;
        for (int i = DEPTH - 2; i >= 0; i--) begin
            adv[i] = valid_q[i] & (~valid_q[i+1] | adv[i+1]);
        end
    end

    // Reset is folded in because the cleared valid bits alone would otherwise report ready.
    assign in_ready = ~reset & ~bus.flush & (~valid_q[0] | adv[0]);
    assign in_hs    = bus.in_valid & in_ready;
    assign out_hs   = valid_q[DEPTH-1] & bus.out_ready;

    // Per-stage load/drain/hold decisions; flush clears valids but leaves data untouched.
    always_comb begin
        load    = '0;
        load[0] = in_hs;
        for (int i = 1; i < DEPTH; i++) begin
            load[i] = adv[i-1];
        end
        for (int i = 0; i < DEPTH; i++) begin
            data_d[i] = data_q[i];
            if (bus.flush) begin
                valid_d[i] = 1'b0;
            end else if (load[i]) begin
                valid_d[i] = 1'b1;
            end else if (adv[i]) begin
                valid_d[i] = 1'b0;
            end else begin
                valid_d[i] = valid_q[i];
            end
        end
        if (load[0] && !bus.flush) begin
            data_d[0] = bus.in_data;
        end
        for (int i = 1; i < DEPTH; i++) begin
            if (load[i] && !bus.flush) begin
                data_d[i] = data_q[i-1];
            end
        end
    end

    // Stage registers; async reset discards any in-flight words.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                data_q[i] <= RVAL;
            end
        end else begin
            valid_q <= valid_d;
            for (int i = 0; i < DEPTH; i++) begin
                data_q[i] <= data_d[i];
            end
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = valid_q[DEPTH-1];
    assign bus.out_data  = data_q[DEPTH-1];

`ifdef DFFR_PIPE_OCC_EN
    localparam int OCC_W = $clog2(DEPTH + 1);

    logic [OCC_W-1:0] occ_q;
    logic [OCC_W-1:0] occ_d;

    // Occupancy tracks handshakes rather than recounting valid bits each cycle.
    always_comb begin
        occ_d = occ_q;
        if (bus.flush) begin
            occ_d = '0;
        end else if (in_hs && !out_hs) begin
            occ_d = occ_q + OCC_W'(1);
        end else if (out_hs && !in_hs) begin
            occ_d = occ_q - OCC_W'(1);
        end
    end

    // Occupancy register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            occ_q <= '0;
        end else begin
            occ_q <= occ_d;
        end
    end

    assign bus.occupancy = occ_q;
`endif

endmodule

// File: tb/tb_dffr_pipeline.sv
// tb/tb_dffr_pipeline.sv - scoreboard bench for dffr_pipeline (WIDTH=8, DEPTH=3, RVAL=8'hA5)
module tb_dffr_pipeline;

    localparam int         WIDTH = 8;
    localparam int         DEPTH = 3;
    localparam logic [7:0] RVAL  = 8'hA5;

    typedef struct {
        logic [7:0] d;
        int         c;
    } exp_t;

    logic clk;
    logic reset;
    int   cyc;
    int   n_vec;
    int   n_fail;
    bit   mon_en;
    bit   lat_chk;
    exp_t q[$];

    dffr_pipeline_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

    dffr_pipeline #(.WIDTH(WIDTH), .DEPTH(DEPTH), .RVAL(RVAL)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // One cycle of stimulus; the accepted word is recorded late in the cycle, after the monitor has sampled.
    task automatic drive(input logic iv, input logic [7:0] d, input logic ordy, input logic fl);
        @(posedge clk);
        #1;
        bus.in_valid  = iv;
        bus.in_data   = d;
        bus.out_ready = ordy;
        bus.flush     = fl;
        #7;
        if (iv && bus.in_ready && !reset) q.push_back('{d, cyc});
    endtask

    // Monitor: the pipeline must behave as an order-preserving queue of capacity DEPTH.
    always @(negedge clk) begin
        if (!reset && mon_en) begin
            int cnt;
            cnt = q.size();
            chk("in_ready", {31'd0, bus.in_ready},
                {31'd0, !bus.flush && (cnt < DEPTH || bus.out_ready)});
`ifdef DFFR_PIPE_OCC_EN
            chk("occupancy", 32'(bus.occupancy), 32'(cnt));
`endif
            if (cnt == 0) begin
                chk("out_valid_empty", {31'd0, bus.out_valid}, 32'd0);
            end else if (bus.out_valid) begin
                chk("out_data", {24'd0, bus.out_data}, {24'd0, q[0].d});
                if (bus.out_ready) begin
                    if (lat_chk) chk("latency", 32'(cyc - q[0].c), 32'(DEPTH));
                    void'(q.pop_front());
                end
            end
            if (bus.flush) q.delete();
        end
    end

    initial begin
        cyc           = 0;
        n_vec         = 0;
        n_fail        = 0;
        mon_en        = 0;
        lat_chk       = 0;
        reset         = 1'b1;
        bus.flush     = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 1'b0;

        // Reset state
        @(posedge clk);
        #3;
        chk("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
        chk("rst_out_data", {24'd0, bus.out_data}, {24'd0, RVAL});
        chk("rst_in_ready", {31'd0, bus.in_ready}, 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        #1;
        chk("post_rst_in_ready", {31'd0, bus.in_ready}, 32'd1);
        mon_en = 1;

        // Streaming with latency check
        lat_chk = 1;
        for (int i = 1; i <= 4; i++) drive(1'b1, 8'(i), 1'b1, 1'b0);
        repeat (4) drive(1'b0, 8'h00, 1'b1, 1'b0);
        lat_chk = 0;

        // Backpressure, then release with a simultaneous push
        drive(1'b1, 8'h10, 1'b0, 1'b0);
        drive(1'b1, 8'h11, 1'b0, 1'b0);
        drive(1'b1, 8'h12, 1'b0, 1'b0);
        drive(1'b1, 8'h13, 1'b0, 1'b0);
        drive(1'b1, 8'h13, 1'b1, 1'b0);
        repeat (5) drive(1'b0, 8'h00, 1'b1, 1'b0);

        // Bubble collapse
        drive(1'b1, 8'h20, 1'b0, 1'b0);
        repeat (2) drive(1'b0, 8'h00, 1'b0, 1'b0);
        drive(1'b1, 8'h21, 1'b0, 1'b0);
        repeat (2) drive(1'b0, 8'h00, 1'b0, 1'b0);
        repeat (4) drive(1'b0, 8'h00, 1'b1, 1'b0);

        // Flush with a competing input
        drive(1'b1, 8'h31, 1'b0, 1'b0);
        drive(1'b1, 8'h32, 1'b0, 1'b0);
        drive(1'b1, 8'h33, 1'b0, 1'b0);
        drive(1'b1, 8'h30, 1'b0, 1'b1);
        repeat (3) drive(1'b0, 8'h00, 1'b1, 1'b0);

        // Occupancy: fill two, push and pop together, drain
        drive(1'b1, 8'h40, 1'b0, 1'b0);
        drive(1'b1, 8'h41, 1'b0, 1'b0);
        repeat (2) drive(1'b0, 8'h00, 1'b0, 1'b0);
        drive(1'b1, 8'h42, 1'b1, 1'b0);
        repeat (5) drive(1'b0, 8'h00, 1'b1, 1'b0);

        // Reset landing mid-transfer
        drive(1'b1, 8'h50, 1'b0, 1'b0);
        drive(1'b1, 8'h51, 1'b0, 1'b0);
        @(posedge clk);
        #3;
        reset = 1'b1;
        #1;
        chk("mid_rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
        chk("mid_rst_out_data", {24'd0, bus.out_data}, {24'd0, RVAL});
        chk("mid_rst_in_ready", {31'd0, bus.in_ready}, 32'd0);
        q.delete();
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        reset        = 1'b0;
        repeat (2) drive(1'b0, 8'h00, 1'b1, 1'b0);

        // Randomised traffic with stalls and occasional flushes
        for (int i = 0; i < 1500; i++) begin
            drive(logic'($urandom_range(0, 99) < 65), 8'($urandom),
                  logic'($urandom_range(0, 99) < 60), logic'($urandom_range(0, 99) < 3));
        end
        repeat (6) drive(1'b0, 8'h00, 1'b1, 1'b0);
        chk("drained", 32'(q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
